// File: rtl/addsub_arbiter.sv
// Round-robin arbiter and sequencer that shares one 32-bit add/sub/SLT unit between two requesters.
// Latency: the op is accepted at edge N, the unit is driven in cycle N+1, and rsp_valid rises in cycle N+2.
// Backpressure: only one op is in flight; req_ready stays 0 until the owner's response handshake completes.
module addsub_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_b0,
  input  logic [31:0] req_a1,
  input  logic [31:0] req_b1,
  input  logic [1:0]  req_op0,
  input  logic [1:0]  req_op1,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic [2:0]  rsp_flags,
  output logic [31:0] au_A,
  output logic [31:0] au_B,
  output logic        au_ctl0,
  output logic        au_ctl1,
  input  logic [31:0] au_out,
  input  logic        au_Zero,
  input  logic        au_Overflow,
  input  logic        au_Cout
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state;
  logic        last;
  logic        owner;
  logic        gnt;
  logic        accept;
  logic        rsp_hs;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [1:0]  sel_op;

  // Round-robin pick: on a tie the requester that did not win last time gets the grant.
  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req_valid[1];
    end
  end

  // Ready goes only to the granted requester, and only while idle.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE) begin
      if (gnt) begin
        req_ready = {req_valid[1], 1'b0};
      end else begin
        req_ready = {1'b0, req_valid[0]};
      end
    end
  end

  // Operand mux for the granted requester; the response path decodes from the registered state.
  always_comb begin
    sel_a     = gnt ? req_a1 : req_a0;
    sel_b     = gnt ? req_b1 : req_b0;
    sel_op    = gnt ? req_op1 : req_op0;
    accept    = |(req_valid & req_ready);
    rsp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
    rsp_hs    = (state == RESP) && rsp_ready[owner];
  end

  // Sequencer: accept, drive the unit for one cycle, capture the result, then hold it until the owner consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      au_A      <= 32'd0;
      au_B      <= 32'd0;
      au_ctl0   <= 1'b0;
      au_ctl1   <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_flags <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            au_A    <= sel_a;
            au_B    <= sel_b;
            au_ctl1 <= sel_op[1];
            // Opcode 10 is folded onto SLT (11).
            au_ctl0 <= sel_op[0] | sel_op[1];
            owner   <= gnt;
            last    <= gnt;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= au_out;
          rsp_flags <= {au_Zero, au_Overflow, au_Cout};
          state     <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench for addsub_arbiter, with a behavioural model of the shared add/sub/SLT unit.
// Expected responses are queued when a request is accepted and compared when the owner's response handshake completes.
// Every wait is bounded, and an expired bound counts as a failure.
module tb_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 0, req_b0 = 0, req_a1 = 0, req_b1 = 0;
  logic [1:0]  req_op0 = 0, req_op1 = 0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [31:0] rsp_data;
  logic [2:0]  rsp_flags;
  logic [31:0] au_A, au_B, au_out;
  logic        au_ctl0, au_ctl1, au_Zero, au_Overflow, au_Cout;

  typedef struct {
    logic [1:0]  port;
    logic [31:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] last_data = 0;
  logic [2:0]  last_flags = 0;

  always #5 clk = ~clk;

  // Reference unit: returns {Zero, Overflow, Cout, out}.
  function automatic logic [34:0] au_model(input logic [31:0] a, input logic [31:0] b,
                                           input logic ctl1, input logic ctl0);
    logic [31:0] bx;
    logic [32:0] s;
    logic [31:0] r;
    logic        ovf;
    bx  = ctl0 ? ~b : b;
    s   = {1'b0, a} + {1'b0, bx} + {32'd0, ctl0};
    r   = s[31:0];
    ovf = (a[31] == bx[31]) && (r[31] != a[31]);
    if (ctl1) r = {31'd0, s[31] ^ ovf};
    return {(r == 32'd0), ovf, s[32], r};
  endfunction

  assign {au_Zero, au_Overflow, au_Cout, au_out} = au_model(au_A, au_B, au_ctl1, au_ctl0);

  addsub_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .au_A(au_A), .au_B(au_B), .au_ctl0(au_ctl0), .au_ctl1(au_ctl1),
    .au_out(au_out), .au_Zero(au_Zero), .au_Overflow(au_Overflow), .au_Cout(au_Cout)
  );

  task automatic chk(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: push on request handshake, pop and compare on response handshake.
  always @(negedge clk) begin
    exp_t        e;
    logic [1:0]  op;
    logic [34:0] m;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (|(req_valid & req_ready)) begin
        if (req_ready[1]) begin
          op = req_op1;
          m  = au_model(req_a1, req_b1, op[1], op[0] | op[1]);
          e.port = 2'b10;
        end else begin
          op = req_op0;
          m  = au_model(req_a0, req_b0, op[1], op[0] | op[1]);
          e.port = 2'b01;
        end
        e.data  = m[31:0];
        e.flags = m[34:32];
        q.push_back(e);
      end
      if (|(rsp_valid & rsp_ready)) begin
        if (q.size() == 0) begin
          chk("spurious_rsp", {33'd0, rsp_valid}, 35'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_port", {33'd0, rsp_valid}, {33'd0, e.port});
          chk("rsp_data", {3'd0, rsp_data}, {3'd0, e.data});
          chk("rsp_flags", {32'd0, rsp_flags}, {32'd0, e.flags});
          last_data  = rsp_data;
          last_flags = rsp_flags;
        end
      end
    end
  end

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present one request, wait for acceptance, then check the unit inputs during EXEC.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] op, input bit wait_done);
    bit ok;
    ok = 1'b0;
    if (p == 0) begin
      req_a0 = a; req_b0 = b; req_op0 = op; req_valid = 2'b01;
    end else begin
      req_a1 = a; req_b1 = b; req_op1 = op; req_valid = 2'b10;
    end
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("accept", {34'd0, ok}, 35'd1);
    tick();
    req_valid = 2'b00;
    chk("exec_au_A", {3'd0, au_A}, {3'd0, a});
    chk("exec_au_B", {3'd0, au_B}, {3'd0, b});
    chk("exec_au_ctl", {33'd0, au_ctl1, au_ctl0}, {33'd0, op[1], op[0] | op[1]});
    if (wait_done) begin
      for (int i = 0; i < 20; i++) begin
        if (q.size() == 0) break;
        tick();
      end
      chk("resp_done", {34'd0, (q.size() == 0)}, 35'd1);
    end
  endtask

  initial begin
    bit [1:0] got;
    #1 watchdog_dummy();
    // Reset state.
    #2;
    chk("rst_rsp_valid", {33'd0, rsp_valid}, 35'd0);
    chk("rst_req_ready", {33'd0, req_ready}, 35'd0);
    chk("rst_rsp_data", {3'd0, rsp_data}, 35'd0);
    chk("rst_rsp_flags", {32'd0, rsp_flags}, 35'd0);
    chk("rst_au", {1'd0, au_A, au_ctl1, au_ctl0}, 35'd0);
    chk("rst_au_B", {3'd0, au_B}, 35'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single ADD from port 0 with explicit cycle timing.
    req_a0 = 5; req_b0 = 7; req_op0 = 2'b00; req_valid = 2'b01;
    #1 chk("add_ready", {33'd0, req_ready}, 35'd1);
    tick();
    req_valid = 2'b11;
    #1;
    chk("add_exec_ready", {33'd0, req_ready}, 35'd0);
    chk("add_exec_rspv", {33'd0, rsp_valid}, 35'd0);
    chk("add_exec_au", {1'd0, au_A, au_ctl1, au_ctl0}, {1'd0, 32'd5, 2'b00});
    chk("add_exec_au_B", {3'd0, au_B}, 35'd7);
    tick();
    req_valid = 2'b00;
    #1;
    chk("add_resp_rspv", {33'd0, rsp_valid}, 35'd1);
    chk("add_resp_ready", {33'd0, req_ready}, 35'd0);
    chk("add_resp_data", {3'd0, rsp_data}, 35'd12);
    chk("add_resp_flags", {32'd0, rsp_flags}, 35'd0);
    tick();
    #1 chk("add_idle_rspv", {33'd0, rsp_valid}, 35'd0);
    tick();

    // SUB with overflow, SLT, and coerced opcode 10, all from port 1.
    issue(1, 32'h8000_0000, 32'd1, 2'b01, 1'b1);
    chk("sub_ovf_data", {3'd0, last_data}, 35'h7FFF_FFFF);
    chk("sub_ovf_flags", {32'd0, last_flags}, 35'b011);
    issue(1, 32'd3, 32'd9, 2'b11, 1'b1);
    chk("slt_data", {3'd0, last_data}, 35'd1);
    issue(1, 32'd3, 32'd9, 2'b10, 1'b1);
    chk("slt10_data", {3'd0, last_data}, 35'd1);

    // Tie fairness after reset: expect grants 0,1,0,1.
    do_reset();
    req_a0 = 100; req_b0 = 1; req_op0 = 2'b00;
    req_a1 = 50;  req_b1 = 8; req_op1 = 2'b01;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 2'b00;
      for (int i = 0; i < 10; i++) begin
        #1;
        if (req_ready != 2'b00) begin
          got = req_ready;
          break;
        end
        tick();
      end
      chk("tie_grant", {33'd0, got}, (k % 2 == 1) ? 35'b10 : 35'b01);
      tick();
    end
    req_valid = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("tie_drain", {3'd0, q.size()}, 35'd0);
    chk("tie_last_data", {3'd0, last_data}, 35'd42);

    // Response backpressure; the non-owner's rsp_ready is asserted and must be ignored.
    rsp_ready = 2'b10;
    issue(0, 32'h7FFF_FFFF, 32'd1, 2'b00, 1'b0);
    tick();
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_rspv", {33'd0, rsp_valid}, 35'b01);
      chk("bp_data", {3'd0, rsp_data}, 35'h8000_0000);
      chk("bp_flags", {32'd0, rsp_flags}, 35'b010);
      chk("bp_ready", {33'd0, req_ready}, 35'd0);
      tick();
    end
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    tick();
    #1;
    chk("bp_idle_rspv", {33'd0, rsp_valid}, 35'd0);
    chk("bp_drain", {3'd0, q.size()}, 35'd0);
    tick();

    // Reset asserted mid-EXEC: outputs clear immediately, and no response follows.
    issue(1, 32'd10, 32'd20, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mrst_au", {1'd0, au_A, au_ctl1, au_ctl0}, 35'd0);
    chk("mrst_data", {3'd0, rsp_data}, 35'd0);
    chk("mrst_rspv", {33'd0, rsp_valid}, 35'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mrst_no_rsp", {33'd0, rsp_valid}, 35'd0);
    end
    req_valid = 2'b11;
    #1 chk("mrst_tie", {33'd0, req_ready}, 35'b01);
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("mrst_drain", {3'd0, q.size()}, 35'd0);

    // Zero flag.
    issue(0, 32'h1234_5678, 32'h1234_5678, 2'b01, 1'b1);
    chk("zero_data", {3'd0, last_data}, 35'd0);
    chk("zero_flags", {32'd0, last_flags}, 35'b101);

    tick();
    chk("final_q_empty", {3'd0, q.size()}, 35'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  task automatic watchdog_dummy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
